// File: rtl/bcd_display_driver.sv
// Binary count to BCD (double-dabble) and two-digit multiplexed 7-seg driver.
// Ports: clk, rst_n, count_in[7:0] -> seg[6:0] {g..a}, an[1:0] {tens,ones}, busy, ovf.
module bcd_display_driver #(
  parameter int REFRESH_DIV    = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit BLANK_LZ       = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] count_in,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       busy,
  output logic       ovf
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [1:0] AN_OFF  = SEG_ACTIVE_LOW ? 2'b11 : 2'b00;
  localparam logic [6:0] DASH    = 7'h40;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_t;

  state_t state, state_nx;

  logic [7:0]    last_val;
  logic [7:0]    cap_val;
  logic [7:0]    sh;
  logic [11:0]   bcd;
  logic [11:0]   bcd_adj;
  logic [2:0]    bit_cnt;
  logic [3:0]    ones;
  logic [3:0]    tens;
  logic [3:0]    hund;
  logic          start;
  logic [CW-1:0] cnt;
  logic          sel;
  logic [6:0]    ones_seg;
  logic [6:0]    tens_seg;
  logic [6:0]    seg_h;
  logic [1:0]    an_h;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [6:0] enc(input logic [3:0] d);
    logic [6:0] s;
    s = 7'h00;
    unique case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = DASH;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    start    = 1'b0;
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (count_in != last_val) begin
          start    = 1'b1;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_cnt == 3'd7) state_nx = COMMIT;
      end
      COMMIT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign bcd_adj = {add3(bcd[11:8]), add3(bcd[7:4]), add3(bcd[3:0])};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_val <= '0;
      cap_val  <= '0;
      sh       <= '0;
      bcd      <= '0;
      bit_cnt  <= '0;
      ones     <= '0;
      tens     <= '0;
      hund     <= '0;
      busy     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            cap_val <= count_in;
            sh      <= count_in;
            bcd     <= '0;
            bit_cnt <= '0;
            busy    <= 1'b1;
          end
        end
        SHIFT: begin
          // Binary MSB enters the BCD chain after the add-3 correction.
          {bcd, sh} <= {bcd_adj[10:0], sh, 1'b0};
          bit_cnt   <= bit_cnt + 3'd1;
        end
        COMMIT: begin
          ones     <= bcd[3:0];
          tens     <= bcd[7:4];
          hund     <= bcd[11:8];
          last_val <= cap_val;
          busy     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign ovf = (hund != 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      sel <= 1'b0;
    end else if (cnt == CNT_MAX) begin
      cnt <= '0;
      sel <= ~sel;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    ones_seg = ovf ? DASH : enc(ones);
    tens_seg = ovf ? DASH : enc(tens);
    if (BLANK_LZ && !ovf && tens == 4'd0) tens_seg = 7'h00;
    seg_h = sel ? tens_seg : ones_seg;
    an_h  = sel ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= SEG_OFF;
      an  <= AN_OFF;
    end else begin
      seg <= SEG_ACTIVE_LOW ? ~seg_h : seg_h;
      an  <= SEG_ACTIVE_LOW ? ~an_h : an_h;
    end
  end

endmodule

// File: tb/tb_bcd_display_driver.sv
// Testbench for bcd_display_driver: three parameter variants in lockstep.
// Expected digits come from decimal arithmetic on the applied value.
module tb_bcd_display_driver;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [7:0]       count_in = 8'd0;
  logic [2:0][6:0]  seg;
  logic [2:0][1:0]  an;
  logic [2:0]       busy;
  logic [2:0]       ovf;

  // index 0: LZ=1 AL=1, index 1: LZ=0 AL=1, index 2: LZ=1 AL=0
  localparam logic [2:0] LZ = 3'b101;
  localparam logic [2:0] AL = 3'b011;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bcd_display_driver #(.REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b1), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .count_in(count_in),
    .seg(seg[0]), .an(an[0]), .busy(busy[0]), .ovf(ovf[0])
  );

  bcd_display_driver #(.REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b1), .BLANK_LZ(1'b0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .count_in(count_in),
    .seg(seg[1]), .an(an[1]), .busy(busy[1]), .ovf(ovf[1])
  );

  bcd_display_driver #(.REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b0), .BLANK_LZ(1'b1)) dut_ah (
    .clk(clk), .rst_n(rst_n), .count_in(count_in),
    .seg(seg[2]), .an(an[2]), .busy(busy[2]), .ovf(ovf[2])
  );

  function automatic logic [6:0] dig(input int d);
    case (d)
      0: return 7'h3F;
      1: return 7'h06;
      2: return 7'h5B;
      3: return 7'h4F;
      4: return 7'h66;
      5: return 7'h6D;
      6: return 7'h7D;
      7: return 7'h07;
      8: return 7'h7F;
      default: return 7'h6F;
    endcase
  endfunction

  // Expected seg for value v in the slot indicated by the observed an.
  function automatic logic [6:0] exp_seg(input int v, input logic [1:0] a,
                                         input bit lz, input bit al);
    logic [1:0] on_a;
    logic [6:0] s;
    int d;
    bit ts;
    on_a = al ? 2'b10 : 2'b01;
    if (a === on_a) ts = 1'b0;
    else if (a === ~on_a) ts = 1'b1;
    else return 7'bxxxxxxx;
    if (v > 99) s = 7'h40;
    else begin
      d = ts ? v / 10 : v % 10;
      s = (ts && lz && d == 0) ? 7'h00 : dig(d);
    end
    return al ? ~s : s;
  endfunction

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    tick;
    for (int i = 0; i < 40 && busy[0]; i++) tick;
    n_cmp++;
    if (busy[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_timeout busy=%b required 0", name, busy[0]);
    end
    tick;
    tick;
  endtask

  task automatic test_reset;
    repeat (3) tick;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (seg[k] !== (AL[k] ? 7'h7F : 7'h00) || an[k] !== (AL[k] ? 2'b11 : 2'b00)
          || busy[k] !== 1'b0 || ovf[k] !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_hold dut%0d seg=%h an=%b busy=%b ovf=%b", k, seg[k], an[k], busy[k], ovf[k]);
      end
    end
    rst_n = 1'b1;
    count_in = 8'd200;
    repeat (3) tick;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (seg[k] !== (AL[k] ? 7'h7F : 7'h00) || an[k] !== (AL[k] ? 2'b11 : 2'b00)
          || busy[k] !== 1'b0 || ovf[k] !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_async dut%0d seg=%h an=%b busy=%b ovf=%b", k, seg[k], an[k], busy[k], ovf[k]);
      end
    end
    tick;
    count_in = 8'd0;
    rst_n = 1'b1;
    repeat (2) tick;
  endtask

  task automatic test_convert47;
    int hi;
    int last_chg;
    int n_chg;
    logic [1:0] prev;
    count_in = 8'd47;
    hi = 0;
    tick;
    for (int i = 0; i < 40 && busy[0]; i++) begin
      hi++;
      tick;
    end
    n_cmp++;
    if (hi != 9) begin
      n_bad++;
      $display("FAIL busy_len got %0d cycles required 9", hi);
    end
    tick;
    for (int c = 0; c < 8; c++) begin
      tick;
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (seg[k] !== exp_seg(47, an[k], LZ[k], AL[k]) || ovf[k] !== 1'b0) begin
          n_bad++;
          $display("FAIL seg47 dut%0d an=%b seg=%h required %h ovf=%b", k, an[k], seg[k],
                   exp_seg(47, an[k], LZ[k], AL[k]), ovf[k]);
        end
      end
    end
    prev = an[0];
    last_chg = -1;
    n_chg = 0;
    for (int c = 0; c < 17; c++) begin
      tick;
      if (an[0] !== prev) begin
        if (last_chg >= 0) begin
          n_cmp++;
          if (c - last_chg != 4) begin
            n_bad++;
            $display("FAIL an_period got %0d cycles required 4", c - last_chg);
          end
        end
        last_chg = c;
        n_chg++;
        prev = an[0];
      end
    end
    n_cmp++;
    if (n_chg < 3) begin
      n_bad++;
      $display("FAIL an_toggles got %0d required >=3", n_chg);
    end
  endtask

  task automatic test_blank5;
    count_in = 8'd5;
    wait_idle("blank5");
    for (int c = 0; c < 8; c++) begin
      tick;
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (seg[k] !== exp_seg(5, an[k], LZ[k], AL[k])) begin
          n_bad++;
          $display("FAIL seg5 dut%0d an=%b seg=%h required %h", k, an[k], seg[k],
                   exp_seg(5, an[k], LZ[k], AL[k]));
        end
      end
    end
  endtask

  task automatic test_boundaries;
    int vals[6] = '{150, 99, 100, 255, 99, 0};
    for (int j = 0; j < 6; j++) begin
      count_in = 8'(vals[j]);
      wait_idle("bound");
      for (int c = 0; c < 8; c++) begin
        tick;
        for (int k = 0; k < 3; k++) begin
          n_cmp++;
          if (seg[k] !== exp_seg(vals[j], an[k], LZ[k], AL[k])
              || ovf[k] !== (vals[j] > 99)) begin
            n_bad++;
            $display("FAIL bound%0d dut%0d an=%b seg=%h required %h ovf=%b", vals[j], k, an[k],
                     seg[k], exp_seg(vals[j], an[k], LZ[k], AL[k]), ovf[k]);
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    count_in = 8'd12;
    tick;
    tick;
    count_in = 8'd34;
    for (int i = 0; i < 40 && busy[0]; i++) tick;
    tick;
    for (int c = 0; c < 8; c++) begin
      tick;
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (seg[k] !== exp_seg(12, an[k], LZ[k], AL[k]) || busy[k] !== 1'b1) begin
          n_bad++;
          $display("FAIL b2b_first dut%0d an=%b seg=%h required %h busy=%b", k, an[k], seg[k],
                   exp_seg(12, an[k], LZ[k], AL[k]), busy[k]);
        end
      end
    end
    wait_idle("b2b");
    for (int c = 0; c < 8; c++) begin
      tick;
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (seg[k] !== exp_seg(34, an[k], LZ[k], AL[k]) || busy[k] !== 1'b0) begin
          n_bad++;
          $display("FAIL b2b_final dut%0d an=%b seg=%h required %h busy=%b", k, an[k], seg[k],
                   exp_seg(34, an[k], LZ[k], AL[k]), busy[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    count_in = 8'd47;
    repeat (4) tick;
    n_cmp++;
    if (busy[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_busy got %b required 1", busy[0]);
    end
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (seg[k] !== (AL[k] ? 7'h7F : 7'h00) || an[k] !== (AL[k] ? 2'b11 : 2'b00)
          || busy[k] !== 1'b0 || ovf[k] !== 1'b0) begin
        n_bad++;
        $display("FAIL mid_reset dut%0d seg=%h an=%b busy=%b ovf=%b", k, seg[k], an[k], busy[k], ovf[k]);
      end
    end
    tick;
    rst_n = 1'b1;
    wait_idle("mid");
    for (int c = 0; c < 8; c++) begin
      tick;
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (seg[k] !== exp_seg(47, an[k], LZ[k], AL[k])) begin
          n_bad++;
          $display("FAIL mid_47 dut%0d an=%b seg=%h required %h", k, an[k], seg[k],
                   exp_seg(47, an[k], LZ[k], AL[k]));
        end
      end
    end
  endtask

  task automatic test_random;
    int v;
    for (int j = 0; j < 12; j++) begin
      v = int'($urandom_range(0, 255));
      count_in = 8'(v);
      wait_idle("rand");
      for (int c = 0; c < 8; c++) begin
        tick;
        for (int k = 0; k < 3; k++) begin
          n_cmp++;
          if (seg[k] !== exp_seg(v, an[k], LZ[k], AL[k]) || ovf[k] !== (v > 99)) begin
            n_bad++;
            $display("FAIL rand%0d dut%0d an=%b seg=%h required %h ovf=%b", v, k, an[k], seg[k],
                     exp_seg(v, an[k], LZ[k], AL[k]), ovf[k]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_convert47;
    test_blank5;
    test_boundaries;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
